instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Fetch stage and reader side of the combinational instruction ROM. Holds the PC and drives
//   imem_addr. Samples the returned 32-bit word in the same cycle and queues {pc, instr} pairs
//   into a small FIFO that decode drains through a valid/ready handshake.
//   Unconditional B is resolved locally, so the fetch PC redirects itself.
//   Execute-stage redirects flush the queue. An all-zero word stops fetching (halt).
// PARAMETERS
//   RESET_PC   64'h0  first fetch address after reset
//   DEPTH      2      FIFO entries (power of 2, >=2)
//   ADDR_W     64     PC / address width
// PORTS
//   CLK             in   1       single clock, rising edge
//   Reset           in   1       synchronous, active-high
//   imem_addr       out  ADDR_W  fetch address to instruction memory (= PC register)
//   imem_data       in   32      instruction word, valid combinationally in the same cycle
//   redirect_valid  in   1       execute-stage redirect (taken branch / CBZ)
//   redirect_pc     in   ADDR_W  redirect target
//   out_valid       out  1       FIFO head valid
//   out_ready       in   1       decode accepts head
//   out_instr       out  32      head instruction
//   out_pc          out  ADDR_W  head instruction address
//   halted          out  1       fetch stopped on zero word
// BEHAVIOUR
//   Reset: PC=RESET_PC, FIFO count=0, out_valid=0, out_instr=0, out_pc=0, state=RUN, halted=0.
//   States: RUN, HALT.
//     RUN->HALT: fetch while imem_data==32'h0; the zero word is not enqueued.
//     HALT->RUN: only on redirect_valid.
//     halted = (state==HALT).
//   deq = out_valid & out_ready. Head advances at the edge. Data is held stable while out_ready=0.
//   fetch_en = RUN & ~redirect_valid & (count<DEPTH | deq).
//     Full with a simultaneous dequeue still fetches; count is unchanged.
//   On fetch_en: enqueue {PC, imem_data}; update PC.
//     - imem_data[31:26]==6'b000101 (B): PC <= PC + sext(imm26<<2), computed 64-bit with wrap.
//       The B word is still enqueued.
//     - otherwise: PC <= PC+4.
//   Full without dequeue: PC holds; imem_addr keeps presenting the same PC.
//   redirect_valid, highest priority below Reset:
//     - flush FIFO (count=0);
//     - PC <= redirect_pc; state <= RUN; no enqueue that cycle.
//     - A deq in the same cycle completes (decode consumed the valid head); its entry is flushed anyway.
//   Latency: word at PC is visible on out_* the cycle after the fetch edge.
//     Redirect to first out_valid = 2 cycles.
//   Reset asserted mid-operation clears everything at the next edge, regardless of other inputs.
//   imem_addr is unaligned only if redirect_pc is unaligned; it is passed through unchanged.
// STRUCTURE
//   cpu_pkg:
//     - localparams OPC_B=6'b000101 and HALT_WORD=32'h0;
//     - ADDR_W default;
//     - fetch state enum {FS_RUN, FS_HALT}.
//   Sub-module fetch_fifo (DEPTH x (ADDR_W+32)):
//     - ports push, pop, flush, full, empty, head;
//     - pointer wrap modulo DEPTH;
//     - count 0..DEPTH.
//   Top contains: PC register, B predecode/adder, state FSM.
// TESTING
//   1 Reset release, memory 0x000=F84003E9, 0x004=F84083EA, out_ready=1
//     -> imem_addr 0x000,0x004,...; out_pc/out_instr 0x000/F84003E9 one cycle later, then 0x004/F84083EA.
//   2 B at 0x028=17FFFFFD
//     -> B enqueued with out_pc=0x028; next imem_addr=0x01C (not 0x02C).
//   3 out_ready=0 for 5 cycles
//     -> count reaches DEPTH, imem_addr frozen, out_instr stable;
//     -> release: entries drain in order, no word lost or duplicated.
//   4 redirect_valid with redirect_pc=0x034 while FIFO full
//     -> next cycle out_valid=0, imem_addr=0x034; following cycle out_pc=0x034, out_instr=D2E24689.
//   5 Sequence ending 0x054=F84283EA, 0x058=0
//     -> 0x054 delivered; halted=1; 0x058 never appears on out_*;
//     -> redirect to 0x000 clears halted.
//   6 Reset asserted mid-stream with full FIFO and redirect_valid=1
//     -> next cycle out_valid=0, halted=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch slice.
package cpu_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 64;
  localparam logic [5:0]  OPC_B          = 6'b000101;
  localparam logic [31:0] HALT_WORD      = 32'h0;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t FS_RUN  = 1'b0;
  localparam fetch_state_t FS_HALT = 1'b1;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction memory read port, execute redirect and decode handshake.
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  halted
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small power-of-two FIFO holding {pc, instr} pairs between fetch and decode.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // Empty head reads as zero so decode never sees stale entries.
  assign head  = empty ? '0 : mem[rptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wptr_q] <= din;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, local B resolution, halt-on-zero FSM and decode queue.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic                     CLK,
  input  logic                     Reset,
  instruction_fetch_unit_if.master bus
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  fetch_state_t      state_q, state_d;

  logic              run, deq, fetch_en, push, is_halt, is_b;
  logic              full, empty;
  logic [ADDR_W-1:0] b_off;

  assign run      = (state_q == FS_RUN);
  assign deq      = bus.out_valid & bus.out_ready;
  assign fetch_en = run & ~bus.redirect_valid & (~full | deq);
  assign is_halt  = (bus.imem_data == HALT_WORD);
  assign is_b     = (bus.imem_data[31:26] == OPC_B);
  assign push     = fetch_en & ~is_halt;
  assign b_off    = {{(ADDR_W-28){bus.imem_data[25]}}, bus.imem_data[25:0], 2'b00};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = FS_RUN;
    end else if (fetch_en) begin
      // The zero word parks the PC on itself so a later redirect is the only way out.
      if (is_halt)   state_d = FS_HALT;
      else if (is_b) pc_d    = pc_q + b_off;
      else           pc_d    = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q    <= RESET_PC[ADDR_W-1:0];
      state_q <= FS_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 32)
  ) u_fifo (
    .clk   (CLK),
    .rst   (Reset),
    .push  (push),
    .pop   (deq),
    .flush (bus.redirect_valid),
    .din   ({pc_q, bus.imem_data}),
    .full  (full),
    .empty (empty),
    .head  ({bus.out_pc, bus.out_instr})
  );

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = ~empty;
  assign bus.halted    = (state_q == FS_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a small combinational ROM.
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  instruction_fetch_unit_if #(.ADDR_W(64)) bus ();

  instruction_fetch_unit #(
    .RESET_PC (64'h0),
    .DEPTH    (2),
    .ADDR_W   (64)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    case (a)
      64'h000: return 32'hF84003E9;
      64'h004: return 32'hF84083EA;
      64'h028: return 32'h17FFFFFD;
      64'h034: return 32'hD2E24689;
      64'h054: return 32'hF84283EA;
      64'h058: return 32'h00000000;
      default: return 32'h91000000 | a[31:0];
    endcase
  endfunction

  assign bus.imem_data = rom(bus.imem_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [63:0] addr, input logic [63:0] pc,
                           input logic [31:0] instr);
    check({tag, "_addr"}, bus.imem_addr, addr);
    check({tag, "_valid"}, {63'b0, bus.out_valid}, 64'd1);
    check({tag, "_pc"}, bus.out_pc, pc);
    check({tag, "_instr"}, {32'b0, bus.out_instr}, {32'b0, instr});
  endtask

  initial begin
    rst                = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    step();
    step();
    check("rst_valid", {63'b0, bus.out_valid}, 64'd0);
    check("rst_instr", {32'b0, bus.out_instr}, 64'd0);
    check("rst_pc", bus.out_pc, 64'd0);
    check("rst_halted", {63'b0, bus.halted}, 64'd0);
    check("rst_addr", bus.imem_addr, 64'h0);

    // 1: sequential fetch, one-cycle latency
    rst = 1'b0;
    step();
    check_out("seq0", 64'h004, 64'h000, 32'hF84003E9);
    step();
    check_out("seq1", 64'h008, 64'h004, 32'hF84083EA);

    // 2: B at 0x028 jumps back to 0x01C
    for (int i = 0; i < 9; i++) step();
    check_out("b", 64'h01C, 64'h028, 32'h17FFFFFD);

    // 3: back-pressure fills the queue and freezes the PC
    bus.out_ready = 1'b0;
    step();
    check_out("stall1", 64'h020, 64'h028, 32'h17FFFFFD);
    for (int i = 0; i < 4; i++) step();
    check_out("stall5", 64'h020, 64'h028, 32'h17FFFFFD);
    bus.out_ready = 1'b1;
    step();
    check_out("drain0", 64'h024, 64'h01C, 32'h9100001C);
    step();
    check_out("drain1", 64'h028, 64'h020, 32'h91000020);
    step();
    check_out("drain2", 64'h01C, 64'h024, 32'h91000024);

    // 4: redirect while full flushes the queue
    bus.out_ready = 1'b0;
    step();
    check_out("full", 64'h01C, 64'h024, 32'h91000024);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h034;
    step();
    check("redir_valid", {63'b0, bus.out_valid}, 64'd0);
    check("redir_addr", bus.imem_addr, 64'h034);
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    step();
    check_out("redir_out", 64'h038, 64'h034, 32'hD2E24689);

    // 5: zero word at 0x058 halts fetch
    for (int i = 0; i < 8; i++) step();
    check_out("last", 64'h058, 64'h054, 32'hF84283EA);
    check("last_halted", {63'b0, bus.halted}, 64'd0);
    step();
    check("halt_flag", {63'b0, bus.halted}, 64'd1);
    check("halt_valid", {63'b0, bus.out_valid}, 64'd0);
    check("halt_addr", bus.imem_addr, 64'h058);
    step();
    step();
    check("halt_hold", {63'b0, bus.halted}, 64'd1);
    check("halt_hold_valid", {63'b0, bus.out_valid}, 64'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h000;
    step();
    check("unhalt_flag", {63'b0, bus.halted}, 64'd0);
    check("unhalt_addr", bus.imem_addr, 64'h000);
    bus.redirect_valid = 1'b0;
    step();
    check_out("restart", 64'h004, 64'h000, 32'hF84003E9);

    // 6: reset beats a simultaneous redirect with a full queue
    bus.out_ready = 1'b0;
    step();
    check_out("refill", 64'h008, 64'h000, 32'hF84003E9);
    rst                = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h034;
    step();
    check("mrst_valid", {63'b0, bus.out_valid}, 64'd0);
    check("mrst_halted", {63'b0, bus.halted}, 64'd0);
    check("mrst_addr", bus.imem_addr, 64'h0);
    check("mrst_pc", bus.out_pc, 64'd0);
    check("mrst_instr", {32'b0, bus.out_instr}, 64'd0);
    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    step();
    check_out("post_rst", 64'h004, 64'h000, 32'hF84003E9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
